// File: rtl/wb_uart_tx.sv
// Wishbone classic slave: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// Status register reports busy/full/empty/overflow and the FIFO fill count.
module wb_uart_tx #(
  parameter int unsigned DIV   = 1085,
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ack_q, ack_d;
  logic [15:0]     dat_q, dat_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [7:0]      mem_q [DEPTH];

  logic            req, wr_data, push, pop, full, empty, bit_end;
  logic [15:0]     status;
  logic            unused_dat;

  assign unused_dat = ^wb_dat_i[15:8];

  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_data = req & wb_we_i & (wb_adr_i == 2'd0);
  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign push    = wr_data & ~full;
  assign bit_end = (div_q == 16'(DIV - 1));
  assign status  = {8'(cnt_q), 4'b0000, ovf_q, empty, full, (state_q != IDLE)};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          state_d = START;
        end
      end
      START: begin
        tx_d  = 1'b0;
        div_d = bit_end ? '0 : div_q + 16'd1;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d  = shift_q[0];
        div_d = bit_end ? '0 : div_q + 16'd1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        div_d = bit_end ? '0 : div_q + 16'd1;
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    ovf_d  = ovf_q;
    if (wr_data && full)
      ovf_d = 1'b1;
    else if (req && wb_we_i && wb_adr_i == 2'd1 && wb_dat_i[3])
      ovf_d = 1'b0;
    ack_d = req;
    dat_d = (req && !wb_we_i && wb_adr_i == 2'd1) ? status : '0;
    irq_d = (cnt_d == '0) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule
